// File: rtl/param_reply_encoder.sv
// param_reply_encoder: collects per-source ack/nak/err events and sends each
// one as a REPLY_LEN-byte UDP payload followed by a packet descriptor.
// Ports: clk, reset (async, active-low); dest_mac/dest_ip latched at packet
//   start; echo_data captured with each event; ack/nak/err[N_SRC] pulses;
//   tx_fifo_data/_write/_full (payload FIFO); tx_fifo_status/_write/_full
//   (descriptor {ip, mac, len}); busy (not IDLE); overflow (sticky).
// Build option: define REPLY_ROUND_ROBIN_EN for round-robin arbitration;
//   without it the lowest pending source index wins.
module param_reply_encoder #(
    parameter int N_SRC     = 3,
    parameter int REPLY_LEN = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [47:0]       dest_mac,
    input  logic [31:0]       dest_ip,
    input  logic [31:0]       echo_data,
    input  logic [N_SRC-1:0]  ack,
    input  logic [N_SRC-1:0]  nak,
    input  logic [N_SRC-1:0]  err,
    output logic [7:0]        tx_fifo_data,
    output logic              tx_fifo_data_write,
    input  logic              tx_fifo_data_full,
    output logic [95:0]       tx_fifo_status,
    output logic              tx_fifo_status_write,
    input  logic              tx_fifo_status_full,
    output logic              busy,
    output logic              overflow
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, SEND_DATA, SEND_STATUS} state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] pending_q;
    logic [1:0]       code_q [N_SRC];
    logic [31:0]      echo_q [N_SRC];
    logic [1:0]       code_new [N_SRC];
    logic [N_SRC-1:0] ev;
    logic [N_SRC-1:0] ovf_hit;
    logic [SW-1:0]    sel_d;
    logic [SW-1:0]    sh_src_q;
    logic [1:0]       sh_code_q;
    logic [31:0]      sh_echo_q;
    logic [31:0]      ip_q;
    logic [47:0]      mac_q;
    logic [2:0]       idx_q;
    logic             overflow_q;
    logic             found;
    logic             load;
    logic             last_byte;
    logic [7:0]       code_byte;
`ifdef REPLY_ROUND_ROBIN_EN
    logic [SW-1:0]    last_q;
    int               best;
`endif

    // Code 1/2/3 = ack/nak/err; err beats nak beats ack in one cycle.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ev[i] = ack[i] | nak[i] | err[i];
            if (err[i])      code_new[i] = 2'd3;
            else if (nak[i]) code_new[i] = 2'd2;
            else             code_new[i] = 2'd1;
        end
    end

`ifdef REPLY_ROUND_ROBIN_EN
    // Pick the pending source at the smallest circular distance after last_q.
    always_comb begin
        sel_d = '0;
        best  = N_SRC;
        for (int j = 0; j < N_SRC; j++) begin
            if (pending_q[j] &&
                ((j - int'(last_q) - 1 + 2 * N_SRC) % N_SRC) < best) begin
                best  = (j - int'(last_q) - 1 + 2 * N_SRC) % N_SRC;
                sel_d = SW'(j);
            end
        end
        found = (best < N_SRC);
    end
`else
    always_comb begin
        sel_d = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (pending_q[j]) sel_d = SW'(j);
        end
        found = |pending_q;
    end
`endif

    assign load      = (state_q == IDLE) && found;
    assign last_byte = (idx_q == 3'(REPLY_LEN - 1));

    // A source being loaded this cycle is no longer "unsent", so a new
    // event on it is not an overflow.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ovf_hit[i] = ev[i] & pending_q[i] & ~(load && sel_d == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                code_q[i] <= '0;
                echo_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (ev[i]) begin
                    pending_q[i] <= 1'b1;
                    code_q[i]    <= code_new[i];
                    echo_q[i]    <= echo_data;
                end else if (load && sel_d == SW'(i)) begin
                    pending_q[i] <= 1'b0;
                end
            end
            if (|ovf_hit) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (found) state_d = SEND_DATA;
            SEND_DATA:   if (!tx_fifo_data_full && last_byte)
                             state_d = SEND_STATUS;
            SEND_STATUS: if (!tx_fifo_status_full) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_src_q  <= '0;
            sh_code_q <= '0;
            sh_echo_q <= '0;
            mac_q     <= '0;
            ip_q      <= '0;
            idx_q     <= '0;
`ifdef REPLY_ROUND_ROBIN_EN
            last_q    <= SW'(N_SRC - 1);
`endif
        end else if (load) begin
            sh_src_q  <= sel_d;
            sh_code_q <= code_q[sel_d];
            sh_echo_q <= echo_q[sel_d];
            mac_q     <= dest_mac;
            ip_q      <= dest_ip;
            idx_q     <= '0;
`ifdef REPLY_ROUND_ROBIN_EN
            last_q    <= sel_d;
`endif
        end else if (state_q == SEND_DATA && !tx_fifo_data_full) begin
            idx_q <= last_byte ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        unique case (sh_code_q)
            2'd1:    code_byte = 8'h06;
            2'd2:    code_byte = 8'h15;
            2'd3:    code_byte = 8'h18;
            default: code_byte = 8'h00;
        endcase
    end

    always_comb begin
        tx_fifo_data         = 8'h00;
        tx_fifo_data_write   = 1'b0;
        tx_fifo_status       = '0;
        tx_fifo_status_write = 1'b0;
        busy                 = (state_q != IDLE);
        unique case (state_q)
            SEND_DATA: begin
                tx_fifo_data_write = !tx_fifo_data_full;
                unique case (idx_q)
                    3'd0:    tx_fifo_data = 8'(sh_src_q);
                    3'd1:    tx_fifo_data = code_byte;
                    3'd2:    tx_fifo_data = sh_echo_q[31:24];
                    3'd3:    tx_fifo_data = sh_echo_q[23:16];
                    3'd4:    tx_fifo_data = sh_echo_q[15:8];
                    3'd5:    tx_fifo_data = sh_echo_q[7:0];
                    default: tx_fifo_data = 8'h00;
                endcase
            end
            SEND_STATUS: begin
                tx_fifo_status_write = !tx_fifo_status_full;
                tx_fifo_status       = {ip_q, mac_q, 16'(REPLY_LEN)};
            end
            default: ;
        endcase
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_param_reply_encoder.sv
// Bench for param_reply_encoder: random event bursts against a packet-level
// model, scoreboard monitor on the FIFO write strobes, directed timing cases.
module tb_param_reply_encoder;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [47:0]  mac_v = '0;
    logic [31:0]  ip_v = '0;
    logic [31:0]  echo_v = '0;
    logic [N-1:0] ack_v = '0, nak_v = '0, err_v = '0;
    logic [7:0]   dout;
    logic         dwr;
    logic         dfull = 1'b0;
    logic [95:0]  sout;
    logic         swr;
    logic         sfull = 1'b0;
    logic         busy, ovf;

    int cyc = 0, checks = 0, errors = 0, nb = 0;
    logic [7:0]  exp_b[$];
    logic [95:0] exp_s[$];
    int dstamp[$], sstamp[$];
    bit force_df = 0, force_sf = 0, bp_en = 0, ovf_m = 0;
    int rr_last = N - 1;
    int ev_cyc = 0;

    param_reply_encoder #(.N_SRC(N), .REPLY_LEN(6)) dut (
        .clk(clk), .reset(rst_n),
        .dest_mac(mac_v), .dest_ip(ip_v), .echo_data(echo_v),
        .ack(ack_v), .nak(nak_v), .err(err_v),
        .tx_fifo_data(dout), .tx_fifo_data_write(dwr),
        .tx_fifo_data_full(dfull),
        .tx_fifo_status(sout), .tx_fifo_status_write(swr),
        .tx_fifo_status_full(sfull),
        .busy(busy), .overflow(ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // FIFO full drivers: forced levels plus optional random backpressure.
    initial forever begin
        @(posedge clk);
        #2;
        dfull = force_df | (bp_en && $urandom_range(0, 2) == 0);
        sfull = force_sf | (bp_en && $urandom_range(0, 2) == 0);
    end

    task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every FIFO write.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            nb = 0;
        end else begin
            if (dwr) begin
                dstamp.push_back(cyc);
                if (nb >= 6) chk("payload_split", nb, 5);
                if (exp_b.size() == 0) chk("unexpected_byte", dout, 96'hx);
                else chk("data_byte", dout, exp_b.pop_front());
                nb++;
            end
            if (swr) begin
                sstamp.push_back(cyc);
                chk("status_after_payload", nb, 6);
                nb = 0;
                if (exp_s.size() == 0) chk("unexpected_status", sout, 96'hx);
                else chk("status_word", sout, exp_s.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    function automatic int code_of(bit a, bit n, bit e);
        if (e) return 3;
        if (n) return 2;
        return a ? 1 : 0;
    endfunction

    function automatic logic [7:0] cbyte(int c);
        case (c)
            1: return 8'h06;
            2: return 8'h15;
            3: return 8'h18;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int pick(logic [N-1:0] m);
`ifdef REPLY_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++)
            if (m[(rr_last + k) % N]) return (rr_last + k) % N;
`else
        for (int j = 0; j < N; j++)
            if (m[j]) return j;
`endif
        return 0;
    endfunction

    task automatic push_pkt(int s, int c, logic [31:0] d);
        exp_b.push_back(8'(s));
        exp_b.push_back(cbyte(c));
        exp_b.push_back(d[31:24]);
        exp_b.push_back(d[23:16]);
        exp_b.push_back(d[15:8]);
        exp_b.push_back(d[7:0]);
        exp_s.push_back({ip_v, mac_v, 16'd6});
    endtask

    task automatic flush_model();
        exp_b.delete();
        exp_s.delete();
        ovf_m   = 0;
        rr_last = N - 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_data", dout, 0);
        chk("rst_data_write", dwr, 0);
        chk("rst_status", sout, 0);
        chk("rst_status_write", swr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", ovf, 0);
        flush_model();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_s.size() != 0 || busy) && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            chk("drain_timeout", exp_s.size(), 0);
            exp_b.delete();
            exp_s.delete();
        end
        tick();
    endtask

    // Burst of events over ncyc cycles. The first cycle's winner is loaded
    // right away; every later event merges into the pending set.
    task automatic run_burst(int ncyc, logic [N-1:0] a0, logic [N-1:0] n0,
                             logic [N-1:0] e0, bit bp);
        logic [N-1:0] pend, a, n, x;
        int pc[N];
        logic [31:0] pe[N];
        int w;
        pend = '0;
        force_df = bp;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                a = a0; n = n0; x = e0;
                ev_cyc = cyc;
            end else begin
                a = N'($urandom) & N'($urandom);
                n = N'($urandom) & N'($urandom);
                x = N'($urandom) & N'($urandom);
            end
            echo_v = $urandom;
            ack_v = a; nak_v = n; err_v = x;
            for (int s = 0; s < N; s++) begin
                if (a[s] | n[s] | x[s]) begin
                    if (pend[s]) ovf_m = 1;
                    pend[s] = 1'b1;
                    pc[s] = code_of(a[s], n[s], x[s]);
                    pe[s] = echo_v;
                end
            end
            if (c == 0) begin
                w = pick(pend);
                push_pkt(w, pc[w], pe[w]);
                pend[w] = 1'b0;
                rr_last = w;
            end
            tick();
        end
        ack_v = '0; nak_v = '0; err_v = '0;
        while (pend != '0) begin
            w = pick(pend);
            push_pkt(w, pc[w], pe[w]);
            pend[w] = 1'b0;
            rr_last = w;
        end
        tick();
        chk("overflow", ovf, ovf_m);
        force_df = 0;
        bp_en = bp;
        wait_drain();
        bp_en = 0;
    endtask

    initial begin
        int e, d0, s0;
        logic [N-1:0] a0, n0, x0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Single ack: exact latency of bytes and status.
        mac_v = 48'h0a1b2c3d4e5f;
        ip_v  = 32'hc0a80001;
        dstamp.delete(); sstamp.delete();
        e = cyc;
        echo_v = 32'h12345678;
        ack_v = 3'b001;
        push_pkt(0, 1, 32'h12345678);
        tick();
        ack_v = '0;
        repeat (12) tick();
        chk("lat_nbytes", dstamp.size(), 6);
        for (int i = 0; i < dstamp.size() && i < 6; i++)
            chk("lat_byte", dstamp[i], e + 2 + i);
        chk("lat_nstatus", sstamp.size(), 1);
        if (sstamp.size() > 0) chk("lat_status", sstamp[0], e + 8);

        // nak and err together on source 1: err code, no overflow.
        run_burst(1, 3'b000, 3'b010, 3'b010, 0);

        // Three sources at once: order and back-to-back gap.
        dstamp.delete(); sstamp.delete();
        run_burst(1, 3'b101, 3'b010, 3'b000, 0);
        chk("b2b_nbytes", dstamp.size(), 18);
        if (dstamp.size() >= 7) chk("b2b_gap", dstamp[6], ev_cyc + 10);
        if (sstamp.size() > 0) chk("b2b_status", sstamp[0], ev_cyc + 8);

        // Backpressure on data after byte2 and on status.
        dstamp.delete(); sstamp.delete();
        e = cyc;
        echo_v = 32'hcafef00d;
        ack_v = 3'b100;
        push_pkt(2, 1, 32'hcafef00d);
        tick();
        ack_v = '0;
        wait_until(e + 5); force_df = 1;
        wait_until(e + 8); force_df = 0;
        wait_until(e + 11); force_sf = 1;
        wait_until(e + 16); force_sf = 0;
        repeat (4) tick();
        chk("bp_nbytes", dstamp.size(), 6);
        if (dstamp.size() >= 6) begin
            chk("bp_byte2", dstamp[2], e + 4);
            chk("bp_byte3", dstamp[3], e + 8);
            chk("bp_byte5", dstamp[5], e + 10);
        end
        if (sstamp.size() > 0) chk("bp_status", sstamp[0], e + 16);

        // Two acks on source 2 while the engine is stalled.
        force_df = 1;
        echo_v = 32'h11111111; ack_v = 3'b001; tick();
        ack_v = '0; tick();
        echo_v = 32'haaaaaaaa; ack_v = 3'b100; tick();
        ack_v = '0; tick();
        echo_v = 32'hbbbbbbbb; ack_v = 3'b100; tick();
        ack_v = '0; tick();
        push_pkt(0, 1, 32'h11111111);
        push_pkt(2, 1, 32'hbbbbbbbb);
        ovf_m = 1;
        chk("ovf_merge", ovf, ovf_m);
        force_df = 0;
        wait_drain();

        // Reset during byte3 abandons the packet.
        dstamp.delete(); sstamp.delete();
        e = cyc;
        echo_v = 32'hdeadbeef;
        ack_v = 3'b010;
        push_pkt(1, 1, 32'hdeadbeef);
        tick();
        ack_v = '0;
        wait_until(e + 5);
        chk("pre_reset_bytes", dstamp.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_write", dwr, 0);
        chk("midrst_status_write", swr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overflow", ovf, 0);
        flush_model();
        repeat (2) tick();
        rst_n = 1'b1;
        d0 = dstamp.size();
        s0 = sstamp.size();
        repeat (20) tick();
        chk("post_reset_bytes", dstamp.size(), d0);
        chk("post_reset_status", sstamp.size(), s0);

        // Random bursts with random backpressure.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            mac_v = {$urandom, $urandom};
            ip_v  = $urandom;
            a0 = '0; n0 = '0; x0 = '0;
            for (int k = 0; k < 50 && (a0 | n0 | x0) == '0; k++) begin
                a0 = N'($urandom) & N'($urandom);
                n0 = N'($urandom) & N'($urandom);
                x0 = N'($urandom) & N'($urandom);
            end
            if ((a0 | n0 | x0) == '0) a0 = 3'b001;
            run_burst($urandom_range(1, 5), a0, n0, x0, 1);
        end

        chk("final_queue_empty", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
